// File: rtl/sky_stacker_pkg.sv
// Shared constants for the sky stacker game: FSM encoding, color codes, screen geometry.
package sky_stacker_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SPAWN = 2'd1;
   localparam logic [1:0] ST_FALL  = 2'd2;
   localparam logic [1:0] ST_OVER  = 2'd3;

   typedef enum logic [1:0] {
      COLOR_EMPTY = 2'b00,
      COLOR_RED   = 2'b01,
      COLOR_GREEN = 2'b10,
      COLOR_BLUE  = 2'b11
   } color_t;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int COORD_W     = 10;
   localparam int MAX_STACK_H = 16;

   // EMPTY would make the block invisible, so it folds onto the first real color.
   function automatic logic [1:0] spawn_color(input logic [1:0] raw);
      return (raw == COLOR_EMPTY) ? 2'(COLOR_RED) : raw;
   endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) feeding spawn position and color.
module spawn_lfsr
   import sky_stacker_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] lfsr
);

   always_ff @(posedge clk) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

endmodule

// File: rtl/drop_controller.sv
// Falling-block sequencer: spawns, drops, scores catches, counts misses and ends the game.
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_SPAWN | one cycle: place new block or end game if the stack is full
//   ST_FALL  | block descending; watch collision, floor and fall tick
//   ST_OVER  | game ended; wait for start
module drop_controller
   import sky_stacker_pkg::*;
#(
   parameter int          TICK_DIV  = 250000,
   parameter int          FALL_STEP = 2,
   parameter int          SPAWN_Y   = 0,
   parameter int          FLOOR_Y   = 440,
   parameter int          X_MIN     = 20,
   parameter int          X_SPAN    = 580,
   parameter int          MAX_STACK = MAX_STACK_H,
   parameter int          LIVES     = 3,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                collision,
   input  logic [COORD_W-1:0]  stack_height,
   output logic                stack_clear,
   output logic [COORD_W-1:0]  fall_x,
   output logic [COORD_W-1:0]  fall_y,
   output logic [1:0]          fall_color,
   output logic                fall_active,
   output logic [7:0]          score,
   output logic [1:0]          lives,
   output logic                game_over
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [1:0]         state;
   logic [CW-1:0]      tick_cnt;
   logic [15:0]        lfsr;
   logic [COORD_W-1:0] raw_x;
   logic [COORD_W-1:0] rand_x;
   logic               start_ok;
   logic               unused_lfsr;

   spawn_lfsr #(.SEED(SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   // Single conditional subtract is enough because X_SPAN >= 512 covers half the 10-bit range.
   assign raw_x  = lfsr[9:0];
   assign rand_x = COORD_W'(X_MIN) +
                   ((raw_x >= COORD_W'(X_SPAN)) ? raw_x - COORD_W'(X_SPAN) : raw_x);
   assign unused_lfsr = ^lfsr[15:12];

   assign start_ok    = start && ((state == ST_IDLE) || (state == ST_OVER));
   assign stack_clear = start_ok && !rst;
   assign game_over   = (state == ST_OVER);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         tick_cnt    <= '0;
         fall_x      <= COORD_W'(X_MIN);
         fall_y      <= COORD_W'(SPAWN_Y);
         fall_color  <= 2'(COLOR_RED);
         fall_active <= 1'b0;
         score       <= 8'd0;
         lives       <= 2'd0;
      end else begin
         case (state)
            ST_IDLE, ST_OVER: begin
               if (start_ok) begin
                  score <= 8'd0;
                  lives <= 2'(LIVES);
                  state <= ST_SPAWN;
               end
            end
            ST_SPAWN: begin
               if (stack_height >= COORD_W'(MAX_STACK)) begin
                  fall_active <= 1'b0;
                  state       <= ST_OVER;
               end else begin
                  fall_x      <= rand_x;
                  fall_color  <= spawn_color(lfsr[11:10]);
                  fall_y      <= COORD_W'(SPAWN_Y);
                  tick_cnt    <= CW'(TICK_DIV - 1);
                  fall_active <= 1'b1;
                  state       <= ST_FALL;
               end
            end
            ST_FALL: begin
               if (collision) begin
                  if (score != 8'hFF) score <= score + 8'd1;
                  fall_active <= 1'b0;
                  fall_y      <= COORD_W'(SPAWN_Y);
                  state       <= ST_SPAWN;
               end else if (fall_y >= COORD_W'(FLOOR_Y)) begin
                  fall_active <= 1'b0;
                  if (lives == 2'd1) begin
                     lives <= 2'd0;
                     state <= ST_OVER;
                  end else begin
                     lives <= lives - 2'd1;
                     state <= ST_SPAWN;
                  end
               end else if (tick_cnt == '0) begin
                  fall_y   <= fall_y + COORD_W'(FALL_STEP);
                  tick_cnt <= CW'(TICK_DIV - 1);
               end else begin
                  tick_cnt <= tick_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_drop_controller.sv
// Scoreboard bench for drop_controller with a 4-cycle fall tick.
module tb_drop_controller;

   localparam int EV_CLEAR = 0;
   localparam int EV_DROP  = 1;
   localparam int EV_SPAWN = 2;
   localparam int EV_OVER  = 3;

   typedef struct {
      int kind;
      int y;
      int lives;
      int score;
      int dur;
      int gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       collision;
   logic [9:0] stack_height;
   logic       stack_clear;
   logic [9:0] fall_x;
   logic [9:0] fall_y;
   logic [1:0] fall_color;
   logic       fall_active;
   logic [7:0] score;
   logic [1:0] lives;
   logic       game_over;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   int cyc = 0;
   int clr_run = 0;
   int last_clear = 0;
   int active_run = 0;
   int last_step = 0;
   int prev_y = 0;
   logic prev_active = 1'b0;
   logic prev_over = 1'b0;

   drop_controller #(.TICK_DIV(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .collision    (collision),
      .stack_height (stack_height),
      .stack_clear  (stack_clear),
      .fall_x       (fall_x),
      .fall_y       (fall_y),
      .fall_color   (fall_color),
      .fall_active  (fall_active),
      .score        (score),
      .lives        (lives),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input int y, input int l, input int s,
                       input int dur, input int gap);
      exp_t e;
      e.kind = kind; e.y = y; e.lives = l; e.score = s; e.dur = dur; e.gap = gap;
      q.push_back(e);
   endtask

   task automatic handle(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected event: got kind %0d want none (t=%0t)", kind, $time);
      end else begin
         e = q.pop_front();
         check("event kind", kind, e.kind);
         if (e.y >= 0)  check("event fall_y", int'(fall_y), e.y);
         check("event lives", int'(lives), e.lives);
         check("event score", int'(score), e.score);
         if (e.dur > 0) check("active duration", active_run, e.dur);
         if (e.gap > 0) check("start to spawn", cyc - last_clear, e.gap);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (stack_clear) begin
         clr_run++;
         if (clr_run == 1) begin
            last_clear = cyc;
            handle(EV_CLEAR);
         end
      end else if (clr_run > 0) begin
         check("stack_clear width", clr_run, 1);
         clr_run = 0;
      end
      if (prev_active && !fall_active) handle(EV_DROP);
      if (!prev_active && fall_active) begin
         handle(EV_SPAWN);
         check("color nonzero", int'(fall_color != 2'b00), 1);
         check("x range", int'(fall_x >= 10'd20 && fall_x <= 10'd599), 1);
         active_run = 0;
         last_step = cyc;
      end else if (prev_active && fall_active && int'(fall_y) != prev_y) begin
         check("fall step", int'(fall_y) - prev_y, 2);
         check("fall tick gap", cyc - last_step, 4);
         last_step = cyc;
      end
      if (fall_active) active_run++;
      else             active_run = 0;
      if (!prev_over && game_over) begin
         handle(EV_OVER);
         check("active in over", int'(fall_active), 0);
      end
      prev_active = fall_active;
      prev_over   = game_over;
      prev_y      = int'(fall_y);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // what: 0 game_over, 1 fall_active, 2 fall_y
   task automatic wait_for(input int what, input int val, input int budget);
      int n = 0;
      int cur;
      cur = (what == 0) ? int'(game_over) : (what == 1) ? int'(fall_active) : int'(fall_y);
      while (cur != val && n < budget) begin
         cycle();
         n++;
         cur = (what == 0) ? int'(game_over) : (what == 1) ? int'(fall_active) : int'(fall_y);
      end
      check("wait target reached", cur, val);
   endtask

   task automatic check_reset();
      check("rst fall_x", int'(fall_x), 20);
      check("rst fall_y", int'(fall_y), 0);
      check("rst fall_color", int'(fall_color), 1);
      check("rst fall_active", int'(fall_active), 0);
      check("rst score", int'(score), 0);
      check("rst lives", int'(lives), 0);
      check("rst game_over", int'(game_over), 0);
      check("rst stack_clear", int'(stack_clear), 0);
   endtask

   initial begin
      int s;
      rst = 1'b1; start = 1'b0; collision = 1'b0; stack_height = 10'd0;
      repeat (3) cycle();
      check_reset();
      rst = 1'b0;
      cycle();

      // game 1: three misses
      push(EV_CLEAR, -1, 0, 0, 0, 0);
      push(EV_SPAWN, 0, 3, 0, 0, 2);
      for (int i = 0; i < 3; i++) begin
         push(EV_DROP, 440, 2 - i, 0, 881, 0);
         if (i < 2) push(EV_SPAWN, 0, 2 - i, 0, 0, 0);
      end
      push(EV_OVER, -1, 0, 0, 0, 0);
      start = 1'b1; cycle(); start = 1'b0;
      wait_for(0, 1, 4000);
      cycle();

      // game 2: collision spanning SPAWN/FALL/SPAWN, mid-fall catch, floor catch, full stack
      push(EV_CLEAR, -1, 0, 0, 0, 0);
      push(EV_SPAWN, 0, 3, 0, 0, 2);
      push(EV_DROP, 0, 3, 1, 1, 0);
      push(EV_SPAWN, 0, 3, 1, 0, 0);
      start = 1'b1; cycle(); start = 1'b0;
      collision = 1'b1; repeat (3) cycle(); collision = 1'b0;

      wait_for(2, 100, 400);
      push(EV_DROP, 0, 3, 2, 0, 0);
      push(EV_SPAWN, 0, 3, 2, 0, 0);
      collision = 1'b1; cycle(); collision = 1'b0;

      wait_for(2, 440, 1000);
      push(EV_DROP, 0, 3, 3, 881, 0);
      push(EV_SPAWN, 0, 3, 3, 0, 0);
      collision = 1'b1; cycle(); collision = 1'b0;

      wait_for(1, 1, 10);
      stack_height = 10'd16;
      push(EV_DROP, 0, 3, 4, 0, 0);
      push(EV_OVER, -1, 3, 4, 0, 0);
      collision = 1'b1; cycle(); collision = 1'b0;
      wait_for(0, 1, 10);
      repeat (5) cycle();
      check("score held in over", int'(score), 4);
      check("lives held in over", int'(lives), 3);

      // game 3: saturate score, then reset mid-fall
      stack_height = 10'd0;
      push(EV_CLEAR, -1, 3, 4, 0, 0);
      push(EV_SPAWN, 0, 3, 0, 0, 2);
      start = 1'b1; cycle(); start = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         wait_for(1, 1, 10);
         s = (k < 255) ? k : 255;
         push(EV_DROP, 0, 3, s, 0, 0);
         push(EV_SPAWN, 0, 3, s, 0, 0);
         collision = 1'b1; cycle(); collision = 1'b0;
      end
      wait_for(2, 50, 200);
      check("score saturated", int'(score), 255);
      push(EV_DROP, 0, 0, 0, 0, 0);
      rst = 1'b1; cycle();
      check_reset();
      rst = 1'b0;
      repeat (5) cycle();
      check("scoreboard drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
